// File: rtl/data_mem_responder.sv
// Multi-cycle data RAM responder for the MEM-stage load/store port (IDLE -> WAIT -> RESP).
// Optional DMR_MISALIGN_CHECK_EN: misaligned half/word accesses complete with resp_err.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_write_ctrl,
    input  logic [2:0]  req_read_ctrl,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        enter_resp;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  wctl_q;
    logic [2:0]  rctl_q;
    logic [31:0] mem [2**ADDR_W];

    logic [31:0]       a, d, word, wword, ld;
    logic [1:0]        w;
    logic [2:0]        r;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [3:0]        be;
    logic              err, accept;
    logic              unused;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign stall      = req_valid & ~resp_valid;
    assign accept     = req_valid & req_ready & ((req_write_ctrl != 2'b00) | (req_read_ctrl != 3'b000));

    // With zero wait states the access completes straight out of IDLE, before the copy is registered
    assign a = (state == IDLE) ? req_addr       : addr_q;
    assign d = (state == IDLE) ? req_wdata      : wdata_q;
    assign w = (state == IDLE) ? req_write_ctrl : wctl_q;
    assign r = (state == IDLE) ? req_read_ctrl  : rctl_q;

    assign idx    = a[ADDR_W+1:2];
    assign unused = ^a[31:ADDR_W+2];
    assign word   = mem[idx];
    assign b      = 8'(word >> {a[1:0], 3'b000});
    assign h      = a[1] ? word[31:16] : word[15:0];

    always_comb begin
        err = ((w != 2'b00) && (r != 3'b000)) || (r[2:1] == 2'b11);
`ifdef DMR_MISALIGN_CHECK_EN
        if (((w == 2'b10) || (r == 3'b010) || (r == 3'b101)) && a[0])
            err = 1'b1;
        if (((w == 2'b11) || (r == 3'b011)) && (a[1:0] != 2'b00))
            err = 1'b1;
`endif
    end

    always_comb begin
        be    = 4'b0000;
        wword = d;
        case (w)
            2'b01:   begin be = 4'b0001 << a[1:0];             wword = {4{d[7:0]}};  end
            2'b10:   begin be = a[1] ? 4'b1100 : 4'b0011;      wword = {2{d[15:0]}}; end
            2'b11:   begin be = 4'b1111;                       wword = d;            end
            default: begin be = 4'b0000;                       wword = d;            end
        endcase
    end

    always_comb begin
        case (r)
            3'b001:  ld = {{24{b[7]}}, b};
            3'b010:  ld = {{16{h[15]}}, h};
            3'b011:  ld = word;
            3'b100:  ld = {24'h0, b};
            3'b101:  ld = {16'h0, h};
            default: ld = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (LATENCY == 0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'd0;
                end
            end
            WAIT: if (cnt == 4'(LAT_M1)) begin
                state_nxt  = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_nxt = cnt + 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wctl_q     <= 2'b00;
            rctl_q     <= 3'b000;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wctl_q  <= req_write_ctrl;
                rctl_q  <= req_read_ctrl;
            end
            if (enter_resp) begin
                resp_rdata <= err ? 32'h0 : ld;
                resp_err   <= err;
            end
        end
    end

    // Storage is deliberately not reset; an aborted access never reaches enter_resp
    always_ff @(posedge clk) begin
        if (enter_resp && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, reset abort, zero-latency streaming, random vs byte model.
module tb_data_mem_responder;
    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_write_ctrl = '0;
    logic [2:0]  req_read_ctrl = '0;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 1'b0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic [1:0]  req_write_ctrl0 = '0;
    logic [2:0]  req_read_ctrl0 = '0;
    logic        req_ready0, resp_valid0, resp_err0, stall0;
    logic [31:0] resp_rdata0;

    int vecs = 0;
    int errs = 0;
    bit stall_ok;
    logic [7:0] mb [256];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write_ctrl(req_write_ctrl), .req_read_ctrl(req_read_ctrl),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall(stall));

    data_mem_responder #(.ADDR_W(AW), .LATENCY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_write_ctrl(req_write_ctrl0), .req_read_ctrl(req_read_ctrl0),
        .req_ready(req_ready0), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .stall(stall0));

    typedef struct {
        logic [1:0]  w;
        logic [2:0]  r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Byte-addressed model of the spec rules
    task automatic model(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er);
        int base, off, ho;
        logic [31:0] wd;
        base = int'(a[7:0]) & ~3;
        off  = int'(a[1:0]);
        ho   = off & 2;
        er   = (w != 0 && r != 0) || r >= 6;
`ifdef DMR_MISALIGN_CHECK_EN
        if ((w == 2 || r == 2 || r == 5) && (off % 2 != 0)) er = 1;
        if ((w == 3 || r == 3) && off != 0) er = 1;
`endif
        rd = 0;
        if (er) return;
        if (w == 1) mb[base+off] = d[7:0];
        if (w == 2) begin mb[base+ho] = d[7:0]; mb[base+ho+1] = d[15:8]; end
        if (w == 3) for (int i = 0; i < 4; i++) mb[base+i] = d[8*i +: 8];
        wd = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
        case (r)
            1: rd = 32'($signed(mb[base+off]));
            2: rd = 32'($signed({mb[base+ho+1], mb[base+ho]}));
            3: rd = wd;
            4: rd = 32'(mb[base+off]);
            5: rd = 32'({mb[base+ho+1], mb[base+ho]});
            default: rd = 0;
        endcase
    endtask

    task automatic access(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        @(posedge clk); #1;
        req_write_ctrl = w; req_read_ctrl = r; req_addr = a; req_wdata = d; req_valid = 1'b1;
        lat = -1; rd = 'x; er = 'x; stall_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                if (stall) stall_ok = 1'b0;
                break;
            end else if (!stall) stall_ok = 1'b0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write_ctrl = 0; req_read_ctrl = 0;
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        logic [31:0] last_sw;

        tbl.push_back('{2'b11, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{2'b00, 3'b011, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{2'b01, 3'b000, 32'h13, 32'h80,       32'h0,        1'b0});
        tbl.push_back('{2'b00, 3'b001, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back('{2'b00, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0});
        tbl.push_back('{2'b00, 3'b011, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0});
        tbl.push_back('{2'b10, 3'b000, 32'h12, 32'h9234,     32'h0,        1'b0});
        tbl.push_back('{2'b00, 3'b010, 32'h12, 32'h0,        32'hFFFF9234, 1'b0});
        tbl.push_back('{2'b00, 3'b101, 32'h12, 32'h0,        32'h00009234, 1'b0});
        tbl.push_back('{2'b00, 3'b011, 32'h10, 32'h0,        32'h9234BEEF, 1'b0});
`ifdef DMR_MISALIGN_CHECK_EN
        tbl.push_back('{2'b00, 3'b011, 32'h11, 32'h0,        32'h0,        1'b1});
`else
        tbl.push_back('{2'b00, 3'b011, 32'h11, 32'h0,        32'h9234BEEF, 1'b0});
`endif
        tbl.push_back('{2'b11, 3'b011, 32'h10, 32'h12345678, 32'h0,        1'b1});
        tbl.push_back('{2'b00, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{2'b00, 3'b011, 32'h410,32'h0,        32'h9234BEEF, 1'b0});

        // Reset state
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk); reset_n = 1'b1;

        for (int i = 0; i < 256; i++) mb[i] = 8'h0;
        for (int i = 0; i < 64; i++) access(2'b11, 3'b000, 32'(i*4), 32'h0, rd, er, lat);

        // Both ctrl fields zero: nothing accepted, stall held
        @(posedge clk); #1; req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("noop_resp_valid", 32'(resp_valid), 32'h0);
            chk("noop_stall", 32'(stall), 32'h1);
        end
        @(posedge clk); #1; req_valid = 1'b0;

        foreach (tbl[i]) begin
            access(tbl[i].w, tbl[i].r, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            model(tbl[i].w, tbl[i].r, tbl[i].addr, tbl[i].wdata, mrd, mer);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("tbl%0d_stall", i), 32'(stall_ok), 32'h1);
        end

        // Reset during WAIT aborts a pending store to a zero word
        @(posedge clk); #1;
        req_write_ctrl = 2'b11; req_read_ctrl = 0; req_addr = 32'h20; req_wdata = 32'h1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("abort_resp_valid", 32'(resp_valid), 32'h0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_resp_err", 32'(resp_err), 32'h0);
        @(posedge clk); @(negedge clk); reset_n = 1'b1;
        access(2'b00, 3'b011, 32'h20, 32'h0, rd, er, lat);
        chk("abort_lw_rdata", rd, 32'h0);
        chk("abort_lw_latency", 32'(lat), 32'd3);

        // Zero-latency instance, request held continuously, alternating SW/LW
        @(posedge clk); #1;
        last_sw = 32'hA5A50000;
        req_addr0 = 32'h4; req_write_ctrl0 = 2'b11; req_read_ctrl0 = 0; req_wdata0 = last_sw;
        req_valid0 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("lat0_valid_c%0d", c), 32'(resp_valid0), 32'(c % 2));
            chk($sformatf("lat0_ready_c%0d", c), 32'(req_ready0), 32'((c + 1) % 2));
            chk($sformatf("lat0_stall_c%0d", c), 32'(stall0), 32'((c + 1) % 2));
            if (c % 4 == 3) chk($sformatf("lat0_rdata_c%0d", c), resp_rdata0, last_sw);
            @(posedge clk); #1;
            if (c % 4 == 1) begin
                req_write_ctrl0 = 0; req_read_ctrl0 = 3'b011;
            end else if (c % 4 == 3) begin
                last_sw = $urandom;
                req_write_ctrl0 = 2'b11; req_read_ctrl0 = 0; req_wdata0 = last_sw;
            end
        end
        req_valid0 = 1'b0;

        // Randomised accesses against the byte model
        for (int n = 0; n < 200; n++) begin
            logic [1:0] w;
            logic [2:0] r;
            logic [31:0] a, d;
            int k;
            k = $urandom_range(0, 9);
            if (k < 4) begin w = 2'($urandom_range(1, 3)); r = 0; end
            else if (k < 9) begin w = 0; r = 3'($urandom_range(1, 5)); end
            else begin w = 2'($urandom); r = 3'($urandom_range(1, 7)); end
            a = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 63))};
            d = $urandom;
            access(w, r, a, d, rd, er, lat);
            model(w, r, a, d, mrd, mer);
            chk($sformatf("rnd%0d_rdata w=%0d r=%0d a=%h", n, w, r, a), rd, mrd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
